multicycle_control: RTL and testbench

- Multi-cycle successor to the single-cycle opcode decoder for the MIPS-subset datapath.
- Moore FSM sequences each instruction over 3-5 cycles: FETCH, DECODE, EXEC/MEM, WB.
- Adds beyond the single-cycle decoder: addi and j support, memory wait-state handshake, sticky illegal-opcode trap, retired-instruction counter.
- Drives the shared-memory multicycle datapath (PC, IR, MDR, A/B, ALUOut registers).

---
 rtl/mc_ctrl_pkg.sv | 60 ++++++
 rtl/mc_ctrl_outdec.sv | 118 +++++++++++
 rtl/multicycle_control.sv | 143 ++++++++++++++
 tb/tb_multicycle_control.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared types and encodings for the multicycle MIPS-subset
//               controller: FSM state enum, opcode constants, ALU/mux
//               select encodings and the retire-state helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

  localparam int STATE_W = 4;

  // Encodings 14 and 15 are unused; the decoder treats them as TRAP and
  // the next-state logic sends them back to IDLE.
  typedef enum logic [STATE_W-1:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    R_EXEC   = 4'd3,
    R_WB     = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WB   = 4'd7,
    MEM_WR   = 4'd8,
    BRANCH   = 4'd9,
    I_EXEC   = 4'd10,
    I_WB     = 4'd11,
    JUMP     = 4'd12,
    TRAP     = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B       = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that always complete an instruction on the edge that leaves
  // them. MEM_WR retires only on its mem_ready cycle and is handled apart.
  function automatic logic is_retire_state(input state_e s);
    return (s == R_WB) || (s == MEM_WB) || (s == BRANCH) ||
           (s == I_WB) || (s == JUMP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_outdec.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_outdec
// Description : Combinational Moore decoder from FSM state to the datapath
//               control word. Only FETCH looks at mem_ready, to gate the IR
//               and PC loads on the cycle the instruction word arrives.
// Ports       : state_i      - current FSM state
//               mem_ready_i  - memory access completes this cycle
//               *_o          - datapath control strobes and selects
//               illegal_op_o - trap flag (held while the FSM sits in TRAP)
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 2
) (
  input  logic [STATE_W-1:0] state_i,
  input  logic               mem_ready_i,
  output logic               pc_write_o,
  output logic               pc_write_cond_o,
  output logic               i_or_d_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               ir_write_o,
  output logic               mem_to_reg_o,
  output logic               reg_dst_o,
  output logic               reg_write_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic [1:0]         pc_source_o,
  output logic               illegal_op_o
);

  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_dst_o       = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = ALUSRCB_B;
    alu_op_o        = ALUOP_W'(ALUOP_ADD);
    pc_source_o     = PCSRC_ALU;
    illegal_op_o    = 1'b0;

    case (state_i)
      IDLE: begin
      end
      FETCH: begin
        // PC+4 is written back alongside the IR load, both only once
        // memory delivers the instruction.
        mem_read_o  = 1'b1;
        alu_src_b_o = ALUSRCB_FOUR;
        alu_op_o    = ALUOP_W'(ALUOP_ADD);
        pc_source_o = PCSRC_ALU;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      DECODE: begin
        // Branch target precomputed into ALUOut while registers are read.
        alu_src_b_o = ALUSRCB_IMM_SH2;
        alu_op_o    = ALUOP_W'(ALUOP_ADD);
      end
      R_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = ALUSRCB_B;
        alu_op_o    = ALUOP_W'(ALUOP_FUNCT);
      end
      R_WB: begin
        reg_dst_o   = 1'b1;
        reg_write_o = 1'b1;
      end
      MEM_ADDR, I_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = ALUSRCB_IMM;
        alu_op_o    = ALUOP_W'(ALUOP_ADD);
      end
      MEM_RD: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
      end
      MEM_WB: begin
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
      end
      MEM_WR: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
      end
      BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_src_b_o     = ALUSRCB_B;
        alu_op_o        = ALUOP_W'(ALUOP_SUB);
        pc_write_cond_o = 1'b1;
        pc_source_o     = PCSRC_ALUOUT;
      end
      I_WB: begin
        reg_write_o = 1'b1;
      end
      JUMP: begin
        pc_write_o  = 1'b1;
        pc_source_o = PCSRC_JUMP;
      end
      default: begin
        // TRAP and any unused encoding: raise the trap flag, nothing else.
        illegal_op_o = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Moore FSM controller for the shared-memory multicycle
//               MIPS-subset datapath (R-type, lw, sw, beq, addi, j).
//               Sequences FETCH / DECODE / EXEC-MEM / WB, stalls on
//               mem_ready, traps on illegal opcodes and counts retired
//               instructions.
// Ports       : clk, rst_n       - clock, async active-low reset
//               op_code          - IR[31:26]
//               mem_ready        - memory access completes this cycle
//               pc_write .. pc_source - datapath control word
//               illegal_op       - sticky trap flag
//               instr_retired    - retired-instruction counter (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] op_code,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [1:0]          pc_source,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    instr_retired
);

  state_e            state_q;
  state_e            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              retire;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. op_code comes straight from IR, which only changes
  // in FETCH, so MEM_ADDR can look at it again to pick read or write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = FETCH;
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        if (op_code == OPCODE_W'(OP_RTYPE)) begin
          state_d = R_EXEC;
        end else if ((op_code == OPCODE_W'(OP_LW)) ||
                     (op_code == OPCODE_W'(OP_SW))) begin
          state_d = MEM_ADDR;
        end else if (op_code == OPCODE_W'(OP_BEQ)) begin
          state_d = BRANCH;
        end else if (op_code == OPCODE_W'(OP_ADDI)) begin
          state_d = I_EXEC;
        end else if (op_code == OPCODE_W'(OP_J)) begin
          state_d = JUMP;
        end else begin
          state_d = TRAP;
        end
      end
      R_EXEC:   state_d = R_WB;
      R_WB:     state_d = FETCH;
      MEM_ADDR: state_d = (op_code == OPCODE_W'(OP_SW)) ? MEM_WR : MEM_RD;
      MEM_RD:   if (mem_ready) state_d = MEM_WB;
      MEM_WB:   state_d = FETCH;
      MEM_WR:   if (mem_ready) state_d = FETCH;
      BRANCH:   state_d = FETCH;
      I_EXEC:   state_d = I_WB;
      I_WB:     state_d = FETCH;
      JUMP:     state_d = FETCH;
      TRAP:     state_d = TRAP;
      default:  state_d = IDLE;
    endcase
  end

  // Retirement counter: bumps on the edge that leaves a completing state.
  // TRAP never retires, so the count freezes there.
  assign retire = is_retire_state(state_q) || ((state_q == MEM_WR) && mem_ready);

  always_comb begin
    cnt_d = cnt_q;
    if (retire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign instr_retired = cnt_q;

  // Output decode: pure function of the state (plus FETCH mem_ready gating),
  // so every strobe falls with the asynchronous reset of state_q.
  mc_ctrl_outdec #(
    .ALUOP_W (ALUOP_W)
  ) u_outdec (
    .state_i         (state_q),
    .mem_ready_i     (mem_ready),
    .pc_write_o      (pc_write),
    .pc_write_cond_o (pc_write_cond),
    .i_or_d_o        (i_or_d),
    .mem_read_o      (mem_read),
    .mem_write_o     (mem_write),
    .ir_write_o      (ir_write),
    .mem_to_reg_o    (mem_to_reg),
    .reg_dst_o       (reg_dst),
    .reg_write_o     (reg_write),
    .alu_src_a_o     (alu_src_a),
    .alu_src_b_o     (alu_src_b),
    .alu_op_o        (alu_op),
    .pc_source_o     (pc_source),
    .illegal_op_o    (illegal_op)
  );

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Directed self-checking bench for multicycle_control. A
//               second instance with a 3-bit counter exercises wraparound.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  // Packed control word order:
  // pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  // mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
  // alu_op[1:0], pc_source[1:0], illegal_op
  localparam logic [16:0] C_IDLE       = 17'b0;
  localparam logic [16:0] C_FETCH_RDY  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_FETCH_WAIT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_R_EXEC     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0};
  localparam logic [16:0] C_R_WB       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_MEM_ADDR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_MEM_RD     = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_MEM_WB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_MEM_WR     = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_BRANCH     = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0};
  localparam logic [16:0] C_JUMP       = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0};
  localparam logic [16:0] C_TRAP       = 17'b1;

  localparam logic [5:0] T_R   = 6'b000000;
  localparam logic [5:0] T_LW  = 6'b100011;
  localparam logic [5:0] T_SW  = 6'b101011;
  localparam logic [5:0] T_BEQ = 6'b000100;
  localparam logic [5:0] T_J   = 6'b000010;
  localparam logic [5:0] T_BAD = 6'b111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  op_code = 6'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [31:0] instr_retired;
  logic [16:0] ctrl;

  logic        rst2_n = 1'b0;
  logic [5:0]  op2 = 6'b000010;
  logic        mr2 = 1'b1;
  logic        p2_pcw, p2_pcwc, p2_iord, p2_mrd, p2_mwr, p2_irw;
  logic        p2_m2r, p2_rdst, p2_rwr, p2_srca, p2_ill;
  logic [1:0]  p2_srcb, p2_aluop, p2_pcsrc;
  logic [2:0]  cnt2;

  int n_pass = 0;
  int n_total = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  assign ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                 alu_op, pc_source, illegal_op};

  always @(negedge clk) begin
    if (mem_read && mem_write) overlap++;
  end

  multicycle_control #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op),
    .instr_retired(instr_retired)
  );

  multicycle_control #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(3)) dut_wrap (
    .clk(clk), .rst_n(rst2_n), .op_code(op2), .mem_ready(mr2),
    .pc_write(p2_pcw), .pc_write_cond(p2_pcwc), .i_or_d(p2_iord),
    .mem_read(p2_mrd), .mem_write(p2_mwr), .ir_write(p2_irw),
    .mem_to_reg(p2_m2r), .reg_dst(p2_rdst), .reg_write(p2_rwr),
    .alu_src_a(p2_srca), .alu_src_b(p2_srcb), .alu_op(p2_aluop),
    .pc_source(p2_pcsrc), .illegal_op(p2_ill),
    .instr_retired(cnt2)
  );

  // Every task starts and ends at posedge+2 of a cycle.
  task automatic test_reset();
    rst_n = 1'b0; op_code = T_R; mem_ready = 1'b0;
    @(posedge clk); #2;
    n_total++;
    if (ctrl !== C_IDLE) $display("FAIL reset_ctrl got %b want %b", ctrl, C_IDLE); else n_pass++;
    n_total++;
    if (instr_retired !== 32'd0) $display("FAIL reset_cnt got %0d want 0", instr_retired); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    logic [16:0] exp [5] = '{C_IDLE, C_FETCH_RDY, C_DECODE, C_R_EXEC, C_R_WB};
    op_code = T_R;
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1; #1;
      n_total++;
      if (ctrl !== exp[i]) $display("FAIL rtype_c%0d got %b want %b", i, ctrl, exp[i]); else n_pass++;
      @(posedge clk); #2;
    end
    n_total++;
    if (instr_retired !== 32'd1) $display("FAIL rtype_cnt got %0d want 1", instr_retired); else n_pass++;
  endtask

  task automatic test_lw_wait();
    logic [16:0] exp [7] = '{C_FETCH_RDY, C_DECODE, C_MEM_ADDR, C_MEM_RD, C_MEM_RD, C_MEM_RD, C_MEM_WB};
    logic        mr  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    op_code = T_LW;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr[i]; #1;
      n_total++;
      if (ctrl !== exp[i]) $display("FAIL lw_c%0d got %b want %b", i, ctrl, exp[i]); else n_pass++;
      @(posedge clk); #2;
    end
    n_total++;
    if (instr_retired !== 32'd2) $display("FAIL lw_cnt got %0d want 2", instr_retired); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp [7] = '{C_FETCH_RDY, C_DECODE, C_MEM_ADDR, C_MEM_WR, C_FETCH_RDY, C_DECODE, C_BRANCH};
    logic [5:0]  ops [7] = '{T_SW, T_SW, T_SW, T_SW, T_BEQ, T_BEQ, T_BEQ};
    int          wr_cycles = 0;
    for (int i = 0; i < 7; i++) begin
      op_code = ops[i]; mem_ready = 1'b1; #1;
      if (mem_write && i_or_d) wr_cycles++;
      n_total++;
      if (ctrl !== exp[i]) $display("FAIL swbeq_c%0d got %b want %b", i, ctrl, exp[i]); else n_pass++;
      @(posedge clk); #2;
    end
    n_total++;
    if (wr_cycles !== 1) $display("FAIL sw_write_cycles got %0d want 1", wr_cycles); else n_pass++;
    n_total++;
    if (instr_retired !== 32'd4) $display("FAIL swbeq_cnt got %0d want 4", instr_retired); else n_pass++;
  endtask

  task automatic test_jump();
    logic [16:0] exp [4] = '{C_FETCH_WAIT, C_FETCH_RDY, C_DECODE, C_JUMP};
    logic        mr  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    op_code = T_J;
    for (int i = 0; i < 4; i++) begin
      mem_ready = mr[i]; #1;
      n_total++;
      if (ctrl !== exp[i]) $display("FAIL j_c%0d got %b want %b", i, ctrl, exp[i]); else n_pass++;
      @(posedge clk); #2;
    end
    n_total++;
    if (instr_retired !== 32'd5) $display("FAIL j_cnt got %0d want 5", instr_retired); else n_pass++;
  endtask

  task automatic test_trap();
    logic [16:0] e;
    op_code = T_BAD;
    for (int i = 0; i < 22; i++) begin
      e = (i == 0) ? C_FETCH_RDY : ((i == 1) ? C_DECODE : C_TRAP);
      mem_ready = 1'b1; #1;
      n_total++;
      if (ctrl !== e) $display("FAIL trap_c%0d got %b want %b", i, ctrl, e); else n_pass++;
      @(posedge clk); #2;
    end
    n_total++;
    if (instr_retired !== 32'd5) $display("FAIL trap_frozen_cnt got %0d want 5", instr_retired); else n_pass++;
    rst_n = 1'b0; #1;
    n_total++;
    if (illegal_op !== 1'b0) $display("FAIL trap_clear got %b want 0", illegal_op); else n_pass++;
    n_total++;
    if (instr_retired !== 32'd0) $display("FAIL trap_rst_cnt got %0d want 0", instr_retired); else n_pass++;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    logic [16:0] exp [9] = '{C_IDLE, C_FETCH_RDY, C_DECODE, C_JUMP, C_FETCH_RDY, C_DECODE, C_MEM_ADDR, C_MEM_WR, C_MEM_WR};
    logic [5:0]  ops [9] = '{T_J, T_J, T_J, T_J, T_SW, T_SW, T_SW, T_SW, T_SW};
    logic        mr  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      op_code = ops[i]; mem_ready = mr[i]; #1;
      n_total++;
      if (ctrl !== exp[i]) $display("FAIL midwr_c%0d got %b want %b", i, ctrl, exp[i]); else n_pass++;
      @(posedge clk); #2;
    end
    mem_ready = 1'b0; #1;
    n_total++;
    if (mem_write !== 1'b1 || instr_retired !== 32'd1)
      $display("FAIL midwr_hold got wr=%b cnt=%0d want wr=1 cnt=1", mem_write, instr_retired);
    else n_pass++;
    rst_n = 1'b0; #1;
    n_total++;
    if (mem_write !== 1'b0) $display("FAIL midwr_drop got %b want 0", mem_write); else n_pass++;
    n_total++;
    if (ctrl !== C_IDLE) $display("FAIL midwr_ctrl got %b want %b", ctrl, C_IDLE); else n_pass++;
    n_total++;
    if (instr_retired !== 32'd0) $display("FAIL midwr_cnt got %0d want 0", instr_retired); else n_pass++;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic test_exclusive();
    n_total++;
    if (overlap !== 0) $display("FAIL rd_wr_overlap got %0d want 0", overlap); else n_pass++;
  endtask

  // 3-bit counter instance running back-to-back jumps: the count advances
  // one per 3 cycles after the single IDLE cycle.
  task automatic test_wrap();
    rst2_n = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      @(posedge clk); #2;
      if (e == 22) begin
        n_total++;
        if (cnt2 !== 3'd7) $display("FAIL wrap_full got %0d want 7", cnt2); else n_pass++;
      end
      if (e == 24) begin
        n_total++;
        if (cnt2 !== 3'd7) $display("FAIL wrap_pre got %0d want 7", cnt2); else n_pass++;
      end
      if (e == 25) begin
        n_total++;
        if (cnt2 !== 3'd0) $display("FAIL wrap_zero got %0d want 0", cnt2); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_back_to_back();
    test_jump();
    test_trap();
    test_reset_mid_write();
    test_exclusive();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
